// File: rtl/core_pipe_ctrl.sv
// core_pipe_ctrl: hazard and stall controller for the RV32I in-order pipeline.
// Tracks in-flight register writers in the stages after ID, sequences
// instruction/data memory waits, and drives stage enables, bubble inserts,
// PC write and operand-forwarding selects.
// Build option: CORE_PIPE_FWD_EN enables operand forwarding. Without it,
// every RAW dependency stalls in ID until the writer has retired.
module core_pipe_ctrl #(
  parameter int NREG       = 32,
  parameter int PIPE_DEPTH = 3,   // tracked stages after ID: 1=EX ... PIPE_DEPTH=WB, legal 2..6
  parameter int LOAD_STAGE = 2,   // first stage where load data can be forwarded
  localparam int RAW = $clog2(NREG),
  localparam int FW  = $clog2(PIPE_DEPTH + 1)
) (
  input  logic           CLK,
  input  logic           NRST,
  input  logic           ID_VALID,
  input  logic [RAW-1:0] ID_RS1,
  input  logic [RAW-1:0] ID_RS2,
  input  logic           ID_RS1_USED,
  input  logic           ID_RS2_USED,
  input  logic [RAW-1:0] ID_RD,
  input  logic           ID_RD_WE,
  input  logic           ID_ISLOAD,
  input  logic           EX_REDIRECT,
  input  logic           IMEM_BUSY,
  input  logic           IMEM_DONE,
  input  logic           DMEM_REQ,
  input  logic           DMEM_DONE,
  output logic           PC_WRITE,
  output logic           IFID_WRITE,
  output logic           IDEX_WRITE,
  output logic           EXMEM_WRITE,
  output logic           MEMWB_WRITE,
  output logic           IFID_FLUSH,
  output logic           IDEX_FLUSH,
  output logic           EXMEM_FLUSH,
  output logic [FW-1:0]  FWD_SEL1,
  output logic [FW-1:0]  FWD_SEL2,
  output logic [1:0]     STALL_CAUSE
);

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_HAZARD = 2'd1;
  localparam logic [1:0] CAUSE_IMEM   = 2'd2;
  localparam logic [1:0] CAUSE_DMEM   = 2'd3;

  // Memory wait tracking
  logic imem_pend;
  logic dmem_pend;
  logic imem_wait;
  logic dmem_wait;
  logic gstall;

  // Writer scoreboard, index 1 is the youngest (EX)
  logic [PIPE_DEPTH:1] sb_valid;
  logic [PIPE_DEPTH:1] sb_load;
  logic [RAW-1:0]      sb_rd [1:PIPE_DEPTH];

  // Source matching
  logic          src1_live;
  logic          src2_live;
  logic          hit1;
  logic          hit2;
  logic          lhz1;
  logic          lhz2;
  logic [FW-1:0] idx1;
  logic [FW-1:0] idx2;

  // Hazard resolution
  logic          stall1;
  logic          stall2;
  logic          hazard;
  logic          bubble;
  logic          id_entry_valid;
  logic [FW-1:0] sel1;
  logic [FW-1:0] sel2;

  // A DONE in the same cycle as BUSY/REQ completes the access immediately.
  assign imem_wait = (imem_pend | IMEM_BUSY) & ~IMEM_DONE;
  assign dmem_wait = (dmem_pend | DMEM_REQ) & ~DMEM_DONE;
  assign gstall    = imem_wait | dmem_wait;

  assign src1_live = ID_VALID & ID_RS1_USED & (ID_RS1 != '0);
  assign src2_live = ID_VALID & ID_RS2_USED & (ID_RS2 != '0);

  // x0 is never a real destination, so it is not tracked.
  assign id_entry_valid = ID_VALID & ID_RD_WE & (ID_RD != '0);

  // Youngest matching writer per source: scan oldest to youngest so the smallest stage index wins.
  always_comb begin
    hit1 = 1'b0;
    idx1 = '0;
    lhz1 = 1'b0;
    hit2 = 1'b0;
    idx2 = '0;
    lhz2 = 1'b0;
    for (int k = PIPE_DEPTH; k >= 1; k--) begin
      if (src1_live && sb_valid[k] && (sb_rd[k] == ID_RS1)) begin
        hit1 = 1'b1;
        idx1 = FW'(k);
        lhz1 = sb_load[k] && (k < LOAD_STAGE);
      end
      if (src2_live && sb_valid[k] && (sb_rd[k] == ID_RS2)) begin
        hit2 = 1'b1;
        idx2 = FW'(k);
        lhz2 = sb_load[k] && (k < LOAD_STAGE);
      end
    end
  end

`ifdef CORE_PIPE_FWD_EN
  // Only a load whose data is not yet available has to wait; everything else is forwarded.
  assign stall1 = hit1 & lhz1;
  assign stall2 = hit2 & lhz2;
  assign sel1   = (hit1 & ~lhz1) ? idx1 : '0;
  assign sel2   = (hit2 & ~lhz2) ? idx2 : '0;
`else
  // No forwarding path: a consumer waits until its producer has left WB.
  assign stall1 = hit1;
  assign stall2 = hit2;
  assign sel1   = '0;
  assign sel2   = '0;

  logic unused_fwd;
  assign unused_fwd = ^{idx1, idx2, lhz1, lhz2};
`endif

  assign hazard = stall1 | stall2;

  // A redirect squashes the ID instruction, so it must not enter the scoreboard either.
  assign bubble = EX_REDIRECT | hazard;

  // Stage enables, flushes, forwarding selects and stall cause, in priority order.
  always_comb begin
    PC_WRITE    = 1'b0;
    IFID_WRITE  = 1'b0;
    IDEX_WRITE  = 1'b0;
    EXMEM_WRITE = 1'b0;
    MEMWB_WRITE = 1'b0;
    IFID_FLUSH  = 1'b0;
    IDEX_FLUSH  = 1'b0;
    EXMEM_FLUSH = 1'b0;
    FWD_SEL1    = '0;
    FWD_SEL2    = '0;
    STALL_CAUSE = CAUSE_NONE;
    if (!NRST) begin
      IFID_FLUSH  = 1'b1;
      IDEX_FLUSH  = 1'b1;
      EXMEM_FLUSH = 1'b1;
    end else begin
      FWD_SEL1 = sel1;
      FWD_SEL2 = sel2;
      if (gstall) begin
        // Freeze the whole pipe; a pending redirect waits for the first free cycle.
        STALL_CAUSE = dmem_wait ? CAUSE_DMEM : CAUSE_IMEM;
      end else if (EX_REDIRECT) begin
        PC_WRITE    = 1'b1;
        IFID_FLUSH  = 1'b1;
        IDEX_FLUSH  = 1'b1;
        EXMEM_WRITE = 1'b1;
        MEMWB_WRITE = 1'b1;
      end else if (hazard) begin
        // Hold IF/ID, push a bubble into EX, let older instructions drain.
        IDEX_FLUSH  = 1'b1;
        EXMEM_WRITE = 1'b1;
        MEMWB_WRITE = 1'b1;
        STALL_CAUSE = CAUSE_HAZARD;
      end else begin
        PC_WRITE    = 1'b1;
        IFID_WRITE  = 1'b1;
        IDEX_WRITE  = 1'b1;
        EXMEM_WRITE = 1'b1;
        MEMWB_WRITE = 1'b1;
      end
    end
  end

  // Pending memory flags and scoreboard shift; everything holds during a global stall.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      imem_pend <= 1'b0;
      dmem_pend <= 1'b0;
      sb_valid  <= '0;
      sb_load   <= '0;
      for (int k = 1; k <= PIPE_DEPTH; k++) begin
        sb_rd[k] <= '0;
      end
    end else begin
      imem_pend <= imem_wait;
      dmem_pend <= dmem_wait;
      if (!gstall) begin
        for (int k = PIPE_DEPTH; k >= 2; k--) begin
          sb_valid[k] <= sb_valid[k-1];
          sb_load[k]  <= sb_load[k-1];
          sb_rd[k]    <= sb_rd[k-1];
        end
        sb_valid[1] <= id_entry_valid & ~bubble;
        sb_load[1]  <= id_entry_valid & ~bubble & ID_ISLOAD;
        sb_rd[1]    <= ID_RD;
      end
    end
  end

endmodule

// File: tb/tb_core_pipe_ctrl.sv
// Bench for core_pipe_ctrl (default parameters: 32 regs, 3 tracked stages,
// loads forwardable from stage 2). Expectations follow the build: define
// CORE_PIPE_FWD_EN for both bench and design to check the forwarding variant.
module tb_core_pipe_ctrl;

`ifdef CORE_PIPE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic       CLK;
   logic       NRST;
   logic       ID_VALID;
   logic [4:0] ID_RS1;
   logic [4:0] ID_RS2;
   logic       ID_RS1_USED;
   logic       ID_RS2_USED;
   logic [4:0] ID_RD;
   logic       ID_RD_WE;
   logic       ID_ISLOAD;
   logic       EX_REDIRECT;
   logic       IMEM_BUSY;
   logic       IMEM_DONE;
   logic       DMEM_REQ;
   logic       DMEM_DONE;
   logic       PC_WRITE;
   logic       IFID_WRITE;
   logic       IDEX_WRITE;
   logic       EXMEM_WRITE;
   logic       MEMWB_WRITE;
   logic       IFID_FLUSH;
   logic       IDEX_FLUSH;
   logic       EXMEM_FLUSH;
   logic [1:0] FWD_SEL1;
   logic [1:0] FWD_SEL2;
   logic [1:0] STALL_CAUSE;

   core_pipe_ctrl dut (
      .CLK         (CLK),
      .NRST        (NRST),
      .ID_VALID    (ID_VALID),
      .ID_RS1      (ID_RS1),
      .ID_RS2      (ID_RS2),
      .ID_RS1_USED (ID_RS1_USED),
      .ID_RS2_USED (ID_RS2_USED),
      .ID_RD       (ID_RD),
      .ID_RD_WE    (ID_RD_WE),
      .ID_ISLOAD   (ID_ISLOAD),
      .EX_REDIRECT (EX_REDIRECT),
      .IMEM_BUSY   (IMEM_BUSY),
      .IMEM_DONE   (IMEM_DONE),
      .DMEM_REQ    (DMEM_REQ),
      .DMEM_DONE   (DMEM_DONE),
      .PC_WRITE    (PC_WRITE),
      .IFID_WRITE  (IFID_WRITE),
      .IDEX_WRITE  (IDEX_WRITE),
      .EXMEM_WRITE (EXMEM_WRITE),
      .MEMWB_WRITE (MEMWB_WRITE),
      .IFID_FLUSH  (IFID_FLUSH),
      .IDEX_FLUSH  (IDEX_FLUSH),
      .EXMEM_FLUSH (EXMEM_FLUSH),
      .FWD_SEL1    (FWD_SEL1),
      .FWD_SEL2    (FWD_SEL2),
      .STALL_CAUSE (STALL_CAUSE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct packed {
      logic       nrst;
      logic       valid;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic [4:0] rd;
      logic       we;
      logic       ld;
      logic       redir;
      logic       ibusy;
      logic       idone;
      logic       dreq;
      logic       ddone;
   } inp_t;

   // wr = {IFID, IDEX, EXMEM, MEMWB}, fl = {IFID, IDEX, EXMEM}
   typedef struct packed {
      logic       pc;
      logic [3:0] wr;
      logic [2:0] fl;
      logic [1:0] s1;
      logic [1:0] s2;
      logic [1:0] cause;
   } exp_t;

   typedef struct packed {
      inp_t i;
      exp_t e;
   } vec_t;

   vec_t  vecs[$];
   string tags[$];
   exp_t  exp_q[$];
   int    total = 0;
   int    bad   = 0;

   function automatic inp_t nop();
      inp_t x = '0;
      x.nrst = 1'b1;
      return x;
   endfunction

   function automatic inp_t ins(int rd, bit we, bit ld, int rs1, bit u1, int rs2, bit u2);
      inp_t x = nop();
      x.valid = 1'b1;
      x.rd    = 5'(rd);
      x.we    = we;
      x.ld    = ld;
      x.rs1   = 5'(rs1);
      x.u1    = u1;
      x.rs2   = 5'(rs2);
      x.u2    = u2;
      return x;
   endfunction

   function automatic exp_t mk(bit pc, logic [3:0] wr, logic [2:0] fl, int s1, int s2, int c);
      exp_t e;
      e.pc    = pc;
      e.wr    = wr;
      e.fl    = fl;
      e.s1    = 2'(s1);
      e.s2    = 2'(s2);
      e.cause = 2'(c);
      return e;
   endfunction

   function automatic exp_t adv(int s1, int s2);          return mk(1'b1, 4'b1111, 3'b000, s1, s2, 0); endfunction
   function automatic exp_t haz();                        return mk(1'b0, 4'b0011, 3'b010, 0, 0, 1);   endfunction
   function automatic exp_t red(int s1, int s2);          return mk(1'b1, 4'b0011, 3'b110, s1, s2, 0); endfunction
   function automatic exp_t gst(int c, int s1, int s2);   return mk(1'b0, 4'b0000, 3'b000, s1, s2, c); endfunction
   function automatic exp_t rse();                        return mk(1'b0, 4'b0000, 3'b111, 0, 0, 0);   endfunction

   // Forwarding select expected only when the forwarding build is under test.
   function automatic int f(int k);
      return FWD ? k : 0;
   endfunction

   task automatic add(input inp_t i, input exp_t e, input string t);
      vec_t v;
      v.i = i;
      v.e = e;
      vecs.push_back(v);
      tags.push_back(t);
   endtask

   task automatic drain();
      for (int j = 0; j < 3; j++) add(nop(), adv(0, 0), "drain");
   endtask

   task automatic apply(input inp_t i);
      NRST        = i.nrst;
      ID_VALID    = i.valid;
      ID_RS1      = i.rs1;
      ID_RS1_USED = i.u1;
      ID_RS2      = i.rs2;
      ID_RS2_USED = i.u2;
      ID_RD       = i.rd;
      ID_RD_WE    = i.we;
      ID_ISLOAD   = i.ld;
      EX_REDIRECT = i.redir;
      IMEM_BUSY   = i.ibusy;
      IMEM_DONE   = i.idone;
      DMEM_REQ    = i.dreq;
      DMEM_DONE   = i.ddone;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of test, want finish before 100000");
      $fatal(1, "watchdog");
   end

   initial begin
      inp_t x;
      exp_t got;
      exp_t want;
      x = nop();
      x.nrst = 1'b0;
      apply(x);

      // Reset
      add(x, rse(), "reset0");
      add(x, rse(), "reset1");

      // add x5 ; add x6,x5,x0
      add(ins(5, 1, 0, 0, 0, 0, 0), adv(0, 0), "wr_x5");
`ifdef CORE_PIPE_FWD_EN
      add(ins(6, 1, 0, 5, 1, 0, 1), adv(1, 0), "fwd_ex");
`else
      for (int j = 0; j < 3; j++) add(ins(6, 1, 0, 5, 1, 0, 1), haz(), "raw_stall");
      add(ins(6, 1, 0, 5, 1, 0, 1), adv(0, 0), "raw_issue");
`endif
      drain();

      // x0 never creates a dependency
      add(ins(0, 1, 0, 0, 0, 0, 0), adv(0, 0), "wr_x0");
      add(ins(7, 1, 0, 0, 1, 0, 1), adv(0, 0), "rd_x0");
      drain();

      // Unused sources, non-writing instr, invalid writer, invalid consumer
      add(ins(8, 1, 0, 0, 0, 0, 0), adv(0, 0), "wr_x8");
      add(ins(0, 0, 0, 8, 0, 8, 0), adv(0, 0), "unused_src");
      add(ins(12, 0, 0, 0, 0, 0, 0), adv(0, 0), "nowe_x12");
      add(ins(0, 0, 0, 12, 1, 0, 0), adv(0, 0), "nowe_rd");
      x = ins(13, 1, 0, 0, 0, 0, 0); x.valid = 1'b0;
      add(x, adv(0, 0), "inval_wr");
      add(ins(0, 0, 0, 13, 1, 0, 0), adv(0, 0), "inval_wr_rd");
      add(ins(14, 1, 0, 0, 0, 0, 0), adv(0, 0), "wr_x14");
      x = ins(0, 0, 0, 14, 1, 14, 1); x.valid = 1'b0;
      add(x, adv(0, 0), "inval_cons");
      drain();

      // Load-use
`ifdef CORE_PIPE_FWD_EN
      add(ins(5, 1, 1, 0, 0, 0, 0), adv(0, 0), "lw_x5");
      add(ins(7, 1, 0, 5, 1, 5, 1), haz(), "ld_use");
      add(ins(7, 1, 0, 5, 1, 5, 1), adv(2, 2), "ld_fwd");
`else
      add(ins(9, 1, 1, 0, 0, 0, 0), adv(0, 0), "lw_x9");
      for (int j = 0; j < 3; j++) add(ins(7, 1, 0, 3, 1, 9, 1), haz(), "ld_stall");
      add(ins(7, 1, 0, 3, 1, 9, 1), adv(0, 0), "ld_issue");
`endif
      drain();

      // Two sources matching different stages
      add(ins(1, 1, 0, 0, 0, 0, 0), adv(0, 0), "wr_x1");
      add(ins(2, 1, 0, 0, 0, 0, 0), adv(0, 0), "wr_x2");
`ifdef CORE_PIPE_FWD_EN
      add(ins(3, 1, 0, 1, 1, 2, 1), adv(2, 1), "two_src");
      add(ins(3, 1, 0, 0, 0, 0, 0), adv(0, 0), "wr_x3_again");
      add(ins(0, 0, 0, 3, 1, 0, 0), adv(1, 0), "youngest");
`else
      for (int j = 0; j < 3; j++) add(ins(3, 1, 0, 1, 1, 2, 1), haz(), "two_src_stall");
      add(ins(3, 1, 0, 1, 1, 2, 1), adv(0, 0), "two_src_issue");
`endif
      drain();

      // Scoreboard holds during a dmem stall
      add(ins(4, 1, 0, 0, 0, 0, 0), adv(0, 0), "wr_x4");
      x = ins(0, 0, 0, 4, 1, 0, 0); x.dreq = 1'b1;
      add(x, gst(3, f(1), 0), "hold_t0");
      add(ins(0, 0, 0, 4, 1, 0, 0), gst(3, f(1), 0), "hold_t1");
      x = ins(0, 0, 0, 4, 1, 0, 0); x.ddone = 1'b1;
`ifdef CORE_PIPE_FWD_EN
      add(x, adv(1, 0), "hold_done");
`else
      add(x, haz(), "hold_done");
      add(ins(0, 0, 0, 4, 1, 0, 0), haz(), "hold_raw");
      add(ins(0, 0, 0, 4, 1, 0, 0), haz(), "hold_raw");
      add(ins(0, 0, 0, 4, 1, 0, 0), adv(0, 0), "hold_issue");
`endif
      drain();

      // DMEM_REQ at t0, DMEM_DONE at t4
      x = nop(); x.dreq = 1'b1;
      add(x, gst(3, 0, 0), "dmem_t0");
      for (int j = 0; j < 3; j++) add(nop(), gst(3, 0, 0), "dmem_wait");
      x = nop(); x.ddone = 1'b1;
      add(x, adv(0, 0), "dmem_t4");
      add(nop(), adv(0, 0), "dmem_t5");

      // Same with EX_REDIRECT held: flush only once the stall lifts
      x = nop(); x.dreq = 1'b1; x.redir = 1'b1;
      add(x, gst(3, 0, 0), "dredir_t0");
      x = nop(); x.redir = 1'b1;
      for (int j = 0; j < 3; j++) add(x, gst(3, 0, 0), "dredir_wait");
      x = nop(); x.redir = 1'b1; x.ddone = 1'b1;
      add(x, red(0, 0), "dredir_t4");
      add(nop(), adv(0, 0), "dredir_t5");

      // imem waits and same-cycle completion
      x = nop(); x.ibusy = 1'b1;
      add(x, gst(2, 0, 0), "imem_t0");
      add(nop(), gst(2, 0, 0), "imem_pend");
      x = nop(); x.idone = 1'b1;
      add(x, adv(0, 0), "imem_done");
      x = nop(); x.ibusy = 1'b1; x.idone = 1'b1;
      add(x, adv(0, 0), "imem_same");
      x = nop(); x.dreq = 1'b1; x.ddone = 1'b1;
      add(x, adv(0, 0), "dmem_same");
      x = nop(); x.ibusy = 1'b1; x.dreq = 1'b1;
      add(x, gst(3, 0, 0), "both_wait");
      x = nop(); x.ibusy = 1'b1; x.idone = 1'b1;
      add(x, gst(3, 0, 0), "imem_ok_dmem_wait");
      x = nop(); x.ddone = 1'b1;
      add(x, adv(0, 0), "both_done");

      // Reset in the middle of a dmem wait, stray DONE afterwards
      add(ins(10, 1, 0, 0, 0, 0, 0), adv(0, 0), "wr_x10");
      x = ins(0, 0, 0, 10, 1, 0, 0); x.dreq = 1'b1;
      add(x, gst(3, f(1), 0), "rst_t0");
      add(nop(), gst(3, 0, 0), "rst_t1");
      x = nop(); x.nrst = 1'b0;
      add(x, rse(), "rst_t2");
      add(ins(0, 0, 0, 10, 1, 0, 0), adv(0, 0), "rst_t3");
      add(nop(), adv(0, 0), "rst_t4");
      x = nop(); x.ddone = 1'b1;
      add(x, adv(0, 0), "stray_done");
      add(nop(), adv(0, 0), "rst_t6");

      // Redirect overrides a hazard; a redirected writer never enters the scoreboard
      add(ins(11, 1, 0, 0, 0, 0, 0), adv(0, 0), "wr_x11");
      x = ins(0, 0, 0, 11, 1, 0, 0); x.redir = 1'b1;
      add(x, red(f(1), 0), "redir_haz");
      add(nop(), adv(0, 0), "after_redir");
      x = ins(15, 1, 0, 0, 0, 0, 0); x.redir = 1'b1;
      add(x, red(0, 0), "redir_wr");
      add(ins(0, 0, 0, 15, 1, 0, 0), adv(0, 0), "redir_bubble");

      @(posedge CLK);
      #1;
      for (int n = 0; n < vecs.size(); n++) begin
         apply(vecs[n].i);
         exp_q.push_back(vecs[n].e);
         @(negedge CLK);
         got.pc    = PC_WRITE;
         got.wr    = {IFID_WRITE, IDEX_WRITE, EXMEM_WRITE, MEMWB_WRITE};
         got.fl    = {IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH};
         got.s1    = FWD_SEL1;
         got.s2    = FWD_SEL2;
         got.cause = STALL_CAUSE;
         want = exp_q.pop_front();
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL %s (vec %0d): got pc=%b wr=%b fl=%b sel1=%0d sel2=%0d cause=%0d, want pc=%b wr=%b fl=%b sel1=%0d sel2=%0d cause=%0d",
                     tags[n], n, got.pc, got.wr, got.fl, got.s1, got.s2, got.cause,
                     want.pc, want.wr, want.fl, want.s1, want.s2, want.cause);
         end
         if (NRST && (EXMEM_FLUSH !== 1'b0)) begin
            bad++;
            $display("FAIL %s (vec %0d): got EXMEM_FLUSH=%b out of reset, want 0",
                     tags[n], n, EXMEM_FLUSH);
         end
         @(posedge CLK);
         #1;
      end

      if (total != vecs.size()) begin
         bad++;
         $display("FAIL count: got total=%0d checks, want %0d", total, vecs.size());
      end

      if (bad == 0) $display("PASS");
      else          $display("FAIL: %0d mismatches", bad);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/core_pipe_ctrl.md
Name: core_pipe_ctrl

Overview:
- Parametrised pipeline hazard and stall controller for the RV32I in-order core.
- Tracks in-flight register writers in a shift-register scoreboard covering the stages after ID.
- Generates per-stage write/flush enables, PC write, and operand-forwarding selects.
- Sequences multi-cycle instruction/data memory waits through pending-flag state.

Parameters:
NREG, 32, number of architectural registers; RAW = clog2(NREG)
PIPE_DEPTH, 3, tracked stages after ID (1=EX ... PIPE_DEPTH=WB); legal 2..6
LOAD_STAGE, 2, first stage index at which load data is forwardable; 1 < LOAD_STAGE <= PIPE_DEPTH
FW = clog2(PIPE_DEPTH+1), derived width of forwarding selects

Ports:
CLK  in  1  clock
NRST  in  1  synchronous active-low reset
ID_VALID  in  1  ID holds a real instruction
ID_RS1 / ID_RS2  in  RAW  source registers in ID
ID_RS1_USED / ID_RS2_USED  in  1  source actually read
ID_RD  in  RAW  destination in ID
ID_RD_WE  in  1  ID instruction writes ID_RD
ID_ISLOAD  in  1  ID instruction is a load
EX_REDIRECT  in  1  taken branch/JAL/JALR resolved in EX
IMEM_BUSY  in  1  fetch outstanding
IMEM_DONE  in  1  fetch complete pulse
DMEM_REQ  in  1  load/store issued from MEM, one-cycle pulse
DMEM_DONE  in  1  data access complete pulse
PC_WRITE  out  1  PC update enable
IFID_WRITE / IDEX_WRITE / EXMEM_WRITE / MEMWB_WRITE  out  1  stage register enables
IFID_FLUSH / IDEX_FLUSH / EXMEM_FLUSH  out  1  insert bubble
FWD_SEL1 / FWD_SEL2  out  FW  0=register file, k=forward from stage k
STALL_CAUSE  out  2  0 none, 1 hazard, 2 imem, 3 dmem

Behaviour:
- Reset: NRST synchronous, active-low, clock CLK.
  - Clears scoreboard and pending flags.
  - While NRST low: all WRITE=0, PC_WRITE=0, all FLUSH=1, FWD_SEL*=0, STALL_CAUSE=0.
- Scoreboard: sb[k] = {valid, rd, isload}, k=1..PIPE_DEPTH.
  - Valid only if ID_RD_WE=1 and rd!=0.
- Pending flags:
  - imem_pend: set when IMEM_BUSY & !IMEM_DONE; cleared on IMEM_DONE.
  - dmem_pend: set on DMEM_REQ & !DMEM_DONE; cleared on DMEM_DONE.
  - A DONE and a BUSY/REQ in the same cycle count as completed.
- Global stall:
  - gstall = (imem_pend|IMEM_BUSY)&!IMEM_DONE | (dmem_pend|DMEM_REQ)&!DMEM_DONE.
  - When gstall is high: all WRITE=0, PC_WRITE=0, all FLUSH=0, scoreboard holds.
  - STALL_CAUSE=3 if the dmem term is active, else 2.
  - EX_REDIRECT is ignored while stalled; it is acted on in the first non-stalled cycle.
- Source match: source r with USED=1, r!=0 and ID_VALID=1 matches any valid sb[k] with rd==r. The youngest match (smallest k) governs.
- Hazard stall (gstall=0, no redirect):
  - PC_WRITE=0, IFID_WRITE=0, IDEX_FLUSH=1.
  - EXMEM_WRITE=1, MEMWB_WRITE=1.
  - Scoreboard shifts with a bubble into sb[1]; STALL_CAUSE=1.
- Redirect (gstall=0, EX_REDIRECT=1): overrides any hazard stall.
  - PC_WRITE=1, IFID_FLUSH=1, IDEX_FLUSH=1.
  - All WRITE=1 except flushed stages; sb[1] gets a bubble.
- Normal advance: PC_WRITE=1, all WRITE=1, FLUSH=0.
  - sb[1] <= ID entry; sb[k] <= sb[k-1]; sb[PIPE_DEPTH] retires.
- EXMEM_FLUSH is asserted only during reset.
- FWD_SEL is combinational and valid every cycle; it is 0 when there is no match or forwarding is disabled.
- Two sources may match different stages independently.

Optional Feature:
CORE_PIPE_FWD_EN
- Defined:
  - Youngest match at stage k with isload=1 and k<LOAD_STAGE causes a hazard stall.
  - Any other match drives FWD_SELx=k with no stall.
- Undefined:
  - Any match, including in WB, causes a hazard stall until the writer retires.
  - FWD_SEL1/2 are tied to 0.

Test Plan:
- FWD_EN, defaults: add x5 then add x6,x5,x0 back-to-back -> FWD_SEL1=1, no stall, STALL_CAUSE=0.
- FWD_EN undefined: same pair -> 3 hazard-stall cycles (IDEX_FLUSH=1, PC_WRITE=0, STALL_CAUSE=1), then issue with FWD_SEL1=0.
- FWD_EN, LOAD_STAGE=2: lw x5 then add x7,x5,x5 -> 1 stall cycle, then FWD_SEL1=FWD_SEL2=2.
- Writer rd=x0, consumer rs1=x0 -> no stall, FWD_SEL1=0.
- DMEM_REQ at t0, DMEM_DONE at t4 -> all WRITE=0 and STALL_CAUSE=3 for t0..t3; advance at t4. Repeat with EX_REDIRECT held throughout -> flush applied at t4 only.
- NRST low at t2 of a dmem wait, DMEM_DONE at t5 after release -> flags clear, no stall after reset, stray DONE ignored.
- Redirect and hazard in the same cycle -> IFID_FLUSH=IDEX_FLUSH=PC_WRITE=1, STALL_CAUSE=0.
